// File: rtl/bp_pkg.sv
// Shared parameters, counter encodings and index helpers
// for the fetch-stage branch predictor.
package bp_pkg;

  localparam int XLEN      = 32;
  localparam int BHT_IDX_W = 6;
  localparam int BTB_IDX_W = 4;
  localparam int BHT_N     = 1 << BHT_IDX_W;
  localparam int BTB_N     = 1 << BTB_IDX_W;
  localparam int BTB_TAG_W = XLEN - BTB_IDX_W - 2;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } cnt_e;

  localparam cnt_e BHT_RESET = WNT;

  typedef logic [BHT_IDX_W-1:0] bht_idx_t;
  typedef logic [BTB_IDX_W-1:0] btb_idx_t;
  typedef logic [BTB_TAG_W-1:0] btb_tag_t;

  function automatic cnt_e sat2_next(cnt_e cnt, logic taken);
    unique case (1'b1)
      taken && cnt != ST:   return cnt_e'(cnt + 2'd1);
      !taken && cnt != SNT: return cnt_e'(cnt - 2'd1);
      default:              return cnt;
    endcase
  endfunction

  function automatic bht_idx_t bht_idx(logic [XLEN-1:0] pc);
    return pc[BHT_IDX_W+1:2];
  endfunction

  function automatic btb_idx_t btb_idx(logic [XLEN-1:0] pc);
    return pc[BTB_IDX_W+1:2];
  endfunction

  function automatic btb_tag_t btb_tag(logic [XLEN-1:0] pc);
    return pc[XLEN-1:BTB_IDX_W+2];
  endfunction

endpackage

// File: rtl/bp_if.sv
// Fetch lookup, execute training and perf-counter bundle
// between the pipeline and the branch predictor.
interface bp_if
  import bp_pkg::*;
;

  logic [XLEN-1:0] if_pc;
  logic            if_pred_taken;
  logic [XLEN-1:0] if_pred_target;
  logic            upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic            upd_taken;
  logic [XLEN-1:0] upd_target;
  logic            upd_pred_taken;
  logic [XLEN-1:0] upd_pred_target;
  logic            upd_mispredict;
  logic [31:0]     perf_branches;
  logic [31:0]     perf_misses;

  modport master (
    output if_pc,
    output upd_valid,
    output upd_pc,
    output upd_taken,
    output upd_target,
    output upd_pred_taken,
    output upd_pred_target,
    input  if_pred_taken,
    input  if_pred_target,
    input  upd_mispredict,
    input  perf_branches,
    input  perf_misses
  );

  modport slave (
    input  if_pc,
    input  upd_valid,
    input  upd_pc,
    input  upd_taken,
    input  upd_target,
    input  upd_pred_taken,
    input  upd_pred_target,
    output if_pred_taken,
    output if_pred_target,
    output upd_mispredict,
    output perf_branches,
    output perf_misses
  );

endinterface

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer: combinational
// read port, one synchronous write port.
module bp_btb
  import bp_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] rd_pc,
  output logic            hit,
  output logic [XLEN-1:0] rd_target,
  input  logic            wr_en,
  input  logic [XLEN-1:0] wr_pc,
  input  logic [XLEN-1:0] wr_target
);

  logic [BTB_N-1:0] valid;
  btb_tag_t         tag    [BTB_N];
  logic [XLEN-1:0]  target [BTB_N];

  btb_idx_t rd_idx;
  btb_idx_t wr_idx;

  assign rd_idx = btb_idx(rd_pc);
  assign wr_idx = btb_idx(wr_pc);

  assign hit = valid[rd_idx]
             & (tag[rd_idx] == btb_tag(rd_pc));
  assign rd_target = target[rd_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Only valid bits need reset; payload is gated by them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag[wr_idx]    <= btb_tag(wr_pc);
      target[wr_idx] <= wr_target;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage predictor: 2-bit BHT plus BTB, trained
// from execute, with saturating perf counters.
module branch_predictor
  import bp_pkg::*;
(
  input  logic clk,
  input  logic rst,
  bp_if.slave  bus
);

  cnt_e            bht [BHT_N];
  cnt_e            rd_cnt;
  logic            hit;
  logic [XLEN-1:0] btb_target;
  logic            mispredict;
  logic [31:0]     br_cnt;
  logic [31:0]     miss_cnt;

  bp_btb u_btb (
    .clk       (clk),
    .rst       (rst),
    .rd_pc     (bus.if_pc),
    .hit       (hit),
    .rd_target (btb_target),
    .wr_en     (bus.upd_valid & bus.upd_taken),
    .wr_pc     (bus.upd_pc),
    .wr_target (bus.upd_target)
  );

  assign rd_cnt = bht[bht_idx(bus.if_pc)];

  assign bus.if_pred_taken  = rd_cnt[1] & hit;
  assign bus.if_pred_target = bus.if_pred_taken
                            ? btb_target
                            : bus.if_pc + XLEN'(4);

  assign mispredict = bus.upd_valid
    & ((bus.upd_pred_taken != bus.upd_taken)
     | (bus.upd_taken
        & (bus.upd_pred_target != bus.upd_target)));

  assign bus.upd_mispredict = mispredict;
  assign bus.perf_branches  = br_cnt;
  assign bus.perf_misses    = miss_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_N; i++) begin
        bht[i] <= BHT_RESET;
      end
    end else if (bus.upd_valid) begin
      bht[bht_idx(bus.upd_pc)] <=
        sat2_next(bht[bht_idx(bus.upd_pc)], bus.upd_taken);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_cnt   <= '0;
      miss_cnt <= '0;
    end else begin
      if (bus.upd_valid && br_cnt != '1) begin
        br_cnt <= br_cnt + 32'd1;
      end
      if (mispredict && miss_cnt != '1) begin
        miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor with a queue
// scoreboard for fetch-side predictions.
module tb_branch_predictor;
  import bp_pkg::*;

  logic clk;
  logic rst;

  bp_if bus ();

  branch_predictor dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string           tag;
    logic            taken;
    logic [XLEN-1:0] target;
  } exp_t;

  exp_t        sb [$];
  int          checks;
  int          errors;
  logic        pend_mis;
  logic [31:0] exp_br;
  logic [31:0] exp_miss;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic lookup(string tag, logic [31:0] pc,
                        logic taken, logic [31:0] tgt);
    exp_t e;
    bus.if_pc = pc;
    e.tag     = tag;
    e.taken   = taken;
    e.target  = tgt;
    sb.push_back(e);
  endtask

  task automatic set_upd(logic [31:0] pc, logic taken,
                         logic [31:0] tgt, logic pt,
                         logic [31:0] ptgt, logic mis);
    bus.upd_valid       = 1'b1;
    bus.upd_pc          = pc;
    bus.upd_taken       = taken;
    bus.upd_target      = tgt;
    bus.upd_pred_taken  = pt;
    bus.upd_pred_target = ptgt;
    pend_mis            = mis;
    if (exp_br != '1) exp_br++;
    if (mis && exp_miss != '1) exp_miss++;
  endtask

  task automatic sample();
    exp_t e;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, "_taken"}, 32'(bus.if_pred_taken),
          32'(e.taken));
      chk({e.tag, "_target"}, bus.if_pred_target,
          e.target);
    end
    if (bus.upd_valid || pend_mis) begin
      chk("mispredict", 32'(bus.upd_mispredict),
          32'(pend_mis));
    end
  endtask

  task automatic advance();
    @(negedge clk);
    bus.upd_valid = 1'b0;
    pend_mis      = 1'b0;
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  task automatic chk_perf(string tag);
    chk({tag, "_branches"}, bus.perf_branches, exp_br);
    chk({tag, "_misses"}, bus.perf_misses, exp_miss);
  endtask

  initial begin
    checks              = 0;
    errors              = 0;
    exp_br              = '0;
    exp_miss            = '0;
    pend_mis            = 1'b0;
    rst                 = 1'b1;
    bus.if_pc           = '0;
    bus.upd_valid       = 1'b0;
    bus.upd_pc          = '0;
    bus.upd_taken       = 1'b0;
    bus.upd_target      = '0;
    bus.upd_pred_taken  = 1'b0;
    bus.upd_pred_target = '0;
    @(negedge clk);

    lookup("in_reset", 32'h100, 1'b0, 32'h104);
    cycle();
    chk_perf("in_reset");
    rst = 1'b0;

    lookup("t1", 32'h100, 1'b0, 32'h104);
    cycle();

    set_upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h104, 1'b1);
    lookup("t2_wnt", 32'h100, 1'b0, 32'h104);
    cycle();
    set_upd(32'h100, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0);
    lookup("t2_wt", 32'h100, 1'b1, 32'h200);
    cycle();
    lookup("t2_st", 32'h100, 1'b1, 32'h200);
    cycle();
    chk_perf("t2");
    lookup("t2_lowbits", 32'h103, 1'b1, 32'h200);
    cycle();

    set_upd(32'h100, 1'b0, 32'h0, 1'b1, 32'h200, 1'b1);
    lookup("t3_st", 32'h100, 1'b1, 32'h200);
    cycle();
    set_upd(32'h100, 1'b0, 32'h0, 1'b1, 32'h200, 1'b1);
    lookup("t3_wt", 32'h100, 1'b1, 32'h200);
    cycle();
    set_upd(32'h100, 1'b0, 32'h0, 1'b0, 32'h104, 1'b0);
    lookup("t3_wnt", 32'h100, 1'b0, 32'h104);
    cycle();
    lookup("t3_snt", 32'h100, 1'b0, 32'h104);
    cycle();
    chk_perf("t3");

    set_upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h104, 1'b1);
    cycle();
    set_upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h104, 1'b1);
    lookup("t4_wnt", 32'h100, 1'b0, 32'h104);
    cycle();
    lookup("t4_trained", 32'h100, 1'b1, 32'h200);
    cycle();
    set_upd(32'h140, 1'b1, 32'h300, 1'b0, 32'h144, 1'b1);
    cycle();
    lookup("t4_alias_old", 32'h100, 1'b0, 32'h104);
    cycle();
    lookup("t4_alias_new", 32'h140, 1'b1, 32'h300);
    cycle();

    set_upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h104, 1'b1);
    cycle();
    set_upd(32'h100, 1'b0, 32'h0, 1'b1, 32'h200, 1'b1);
    cycle();
    set_upd(32'h100, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0);
    lookup("t5_same_wt", 32'h100, 1'b1, 32'h200);
    cycle();
    set_upd(32'h100, 1'b0, 32'h0, 1'b1, 32'h200, 1'b1);
    lookup("t5_next_st", 32'h100, 1'b1, 32'h200);
    cycle();
    set_upd(32'h100, 1'b0, 32'h0, 1'b1, 32'h200, 1'b1);
    lookup("t5_wt", 32'h100, 1'b1, 32'h200);
    cycle();
    set_upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h104, 1'b1);
    lookup("t5_same_wnt", 32'h100, 1'b0, 32'h104);
    cycle();
    lookup("t5_after_wnt", 32'h100, 1'b1, 32'h200);
    cycle();
    chk_perf("t5");

    set_upd(32'h100, 1'b1, 32'h204, 1'b1, 32'h200, 1'b1);
    cycle();
    chk_perf("t6_target_miss");

    bus.upd_valid       = 1'b0;
    bus.upd_pc          = 32'h100;
    bus.upd_taken       = 1'b0;
    bus.upd_pred_taken  = 1'b1;
    lookup("t6_idle", 32'h100, 1'b1, 32'h204);
    cycle();
    chk("t6_idle_mis", 32'(bus.upd_mispredict), 32'h0);
    chk_perf("t6_idle");

    exp_br   = '1;
    exp_miss = '1;
    force dut.br_cnt   = 32'hFFFF_FFFF;
    force dut.miss_cnt = 32'hFFFF_FFFF;
    set_upd(32'h100, 1'b1, 32'h208, 1'b1, 32'h204, 1'b1);
    sample();
    @(posedge clk);
    #1;
    release dut.br_cnt;
    release dut.miss_cnt;
    advance();
    chk_perf("t6_sat");
    set_upd(32'h100, 1'b0, 32'h0, 1'b1, 32'h208, 1'b1);
    cycle();
    chk_perf("t6_sat_hold");

    rst      = 1'b1;
    exp_br   = '0;
    exp_miss = '0;
    lookup("rst_mid", 32'h100, 1'b0, 32'h104);
    sample();
    chk_perf("rst_mid");
    advance();
    rst = 1'b0;

    lookup("post_rst_btb", 32'h100, 1'b0, 32'h104);
    cycle();
    lookup("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);
    cycle();
    set_upd(32'h100, 1'b1, 32'h220, 1'b0, 32'h104, 1'b1);
    cycle();
    lookup("post_rst_wnt", 32'h100, 1'b1, 32'h220);
    cycle();
    chk_perf("post_rst");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
